sensor_request_dispatcher: RTL and testbench

Parametrised successor to the single-DHT11 request path. It takes a decoded 2-byte PC request (command, address) from the UART receiver and routes it to one of NUM_SENSORS sensor channels, with a per-request timeout. It then returns a 2-byte response (code, value) to the UART transmitter. It adds address decoding, a one-deep request buffer, timeout detection and a periodic continuous-measurement mode that the fixed single-sensor path lacks.

---
 rtl/dispatcher_pkg.sv | 31 +++
 rtl/dispatcher_request_buffer.sv | 32 +++
 rtl/sensor_request_dispatcher.sv | 227 ++++++++++++++++++++++
 tb/tb_sensor_request_dispatcher.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatcher_pkg.sv
// Shared command/response byte codes and FSM state encoding for the sensor request dispatcher.
package dispatcher_pkg;

    localparam logic [7:0] CMD_STATUS        = 8'h00;
    localparam logic [7:0] CMD_TEMP          = 8'h01;
    localparam logic [7:0] CMD_HUM           = 8'h02;
    localparam logic [7:0] CMD_CONT_TEMP_ON  = 8'h03;
    localparam logic [7:0] CMD_CONT_HUM_ON   = 8'h04;
    localparam logic [7:0] CMD_CONT_TEMP_OFF = 8'h05;
    localparam logic [7:0] CMD_CONT_HUM_OFF  = 8'h06;

    localparam logic [7:0] RSP_OK            = 8'h07;
    localparam logic [7:0] RSP_HUM           = 8'h08;
    localparam logic [7:0] RSP_TEMP          = 8'h09;
    localparam logic [7:0] RSP_CONT_TEMP_OFF = 8'h0A;
    localparam logic [7:0] RSP_CONT_HUM_OFF  = 8'h0B;
    localparam logic [7:0] RSP_SENSOR_ERR    = 8'h1F;
    localparam logic [7:0] RSP_TIMEOUT       = 8'h2F;
    localparam logic [7:0] RSP_BAD_CMD       = 8'hCF;
    localparam logic [7:0] RSP_BAD_ADDR      = 8'hEF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_ISSUE,
        ST_WAIT_SENSOR,
        ST_SEND,
        ST_WAIT_TX
    } state_t;

endpackage

// File: rtl/dispatcher_request_buffer.sv
// One-deep holding register for a request that arrives while the dispatcher is busy.
// A push into a full buffer is dropped so the oldest request is the one that survives.
module dispatcher_request_buffer (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_command,
    input  logic [7:0] push_address,
    input  logic       pop,
    output logic       full,
    output logic [7:0] command,
    output logic [7:0] address
);

    always_ff @(posedge clock) begin
        if (reset) begin
            full    <= 1'b0;
            command <= 8'h00;
            address <= 8'h00;
        end else begin
            if (pop) begin
                full <= 1'b0;
            end
            if (push && !full) begin
                full    <= 1'b1;
                command <= push_command;
                address <= push_address;
            end
        end
    end

endmodule

// File: rtl/sensor_request_dispatcher.sv
// Routes decoded PC requests to one of NUM_SENSORS channels and returns a code/value pair,
// with per-request timeout, a one-deep pending buffer and one periodic continuous-read slot.
module sensor_request_dispatcher
    import dispatcher_pkg::*;
#(
    parameter int NUM_SENSORS    = 32,
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int PERIOD_CYCLES  = 100_000_000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_command,
    input  logic [7:0]               rx_address,
    output logic [NUM_SENSORS-1:0]   sensor_start,
    input  logic [NUM_SENSORS-1:0]   sensor_done,
    input  logic [NUM_SENSORS-1:0]   sensor_error,
    input  logic [16*NUM_SENSORS-1:0] sensor_data,
    output logic                     tx_start,
    output logic [7:0]               tx_code,
    output logic [7:0]               tx_value,
    input  logic                     tx_busy,
    output logic                     busy
);

    localparam int          AW           = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
    localparam logic [7:0]  ADDR_LIMIT   = 8'(NUM_SENSORS);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] PERIOD_LAST  = 32'(PERIOD_CYCLES - 1);

    state_t      state, next_state;
    logic [7:0]  cmd_q, addr_q;
    logic [AW-1:0] addr_idx;
    logic [15:0] sel_data;

    logic        buf_full, buf_pop;
    logic [7:0]  buf_cmd, buf_addr;

    logic        slot_active, slot_hum, tick_pending;
    logic [7:0]  slot_addr;
    logic [31:0] period_cnt, timeout_cnt;

    logic        req_load, slot_load, slot_clear, tick_take, rsp_load, start_tx;
    logic [7:0]  req_cmd, req_addr, rsp_code, rsp_value;

    assign addr_idx = addr_q[AW-1:0];
    assign sel_data = sensor_data[{addr_idx, 4'b0000} +: 16];
    assign busy     = (state != ST_IDLE);

    dispatcher_request_buffer u_request_buffer (
        .clock        (clock),
        .reset        (reset),
        .push         (rx_valid && (state != ST_IDLE)),
        .push_command (rx_command),
        .push_address (rx_address),
        .pop          (buf_pop),
        .full         (buf_full),
        .command      (buf_cmd),
        .address      (buf_addr)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        buf_pop      = 1'b0;
        req_load     = 1'b0;
        req_cmd      = rx_command;
        req_addr     = rx_address;
        slot_load    = 1'b0;
        slot_clear   = 1'b0;
        tick_take    = 1'b0;
        rsp_load     = 1'b0;
        rsp_code     = 8'h00;
        rsp_value    = 8'h00;
        start_tx     = 1'b0;
        sensor_start = '0;
        case (state)
            ST_IDLE: begin
                // A fresh rx_valid coinciding with a full buffer is simply not pushed, i.e. dropped.
                if (buf_full) begin
                    buf_pop    = 1'b1;
                    req_load   = 1'b1;
                    req_cmd    = buf_cmd;
                    req_addr   = buf_addr;
                    next_state = ST_DECODE;
                end else if (rx_valid) begin
                    req_load   = 1'b1;
                    next_state = ST_DECODE;
                end else if (slot_active && tick_pending) begin
                    tick_take  = 1'b1;
                    req_load   = 1'b1;
                    req_cmd    = slot_hum ? CMD_HUM : CMD_TEMP;
                    req_addr   = slot_addr;
                    next_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                next_state = ST_SEND;
                rsp_load   = 1'b1;
                if (addr_q >= ADDR_LIMIT) begin
                    rsp_code  = RSP_BAD_ADDR;
                    rsp_value = addr_q;
                end else if (cmd_q > CMD_CONT_HUM_OFF) begin
                    rsp_code  = RSP_BAD_CMD;
                    rsp_value = cmd_q;
                end else if (cmd_q == CMD_CONT_TEMP_OFF) begin
                    slot_clear = slot_active && !slot_hum;
                    rsp_code   = RSP_CONT_TEMP_OFF;
                end else if (cmd_q == CMD_CONT_HUM_OFF) begin
                    slot_clear = slot_active && slot_hum;
                    rsp_code   = RSP_CONT_HUM_OFF;
                end else begin
                    rsp_load   = 1'b0;
                    slot_load  = (cmd_q == CMD_CONT_TEMP_ON) || (cmd_q == CMD_CONT_HUM_ON);
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                sensor_start[addr_idx] = 1'b1;
                next_state             = ST_WAIT_SENSOR;
            end
            ST_WAIT_SENSOR: begin
                if (sensor_error[addr_idx]) begin
                    rsp_load   = 1'b1;
                    rsp_code   = RSP_SENSOR_ERR;
                    rsp_value  = addr_q;
                    next_state = ST_SEND;
                end else if (sensor_done[addr_idx]) begin
                    rsp_load   = 1'b1;
                    next_state = ST_SEND;
                    if (cmd_q == CMD_STATUS) begin
                        rsp_code = RSP_OK;
                    end else if ((cmd_q == CMD_TEMP) || (cmd_q == CMD_CONT_TEMP_ON)) begin
                        rsp_code  = RSP_TEMP;
                        rsp_value = sel_data[7:0];
                    end else begin
                        rsp_code  = RSP_HUM;
                        rsp_value = sel_data[15:8];
                    end
                end else if (timeout_cnt == TIMEOUT_LAST) begin
                    rsp_load   = 1'b1;
                    rsp_code   = RSP_TIMEOUT;
                    rsp_value  = addr_q;
                    next_state = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!tx_busy) begin
                    start_tx   = 1'b1;
                    next_state = ST_WAIT_TX;
                end
            end
            ST_WAIT_TX: begin
                // tx_start is high only in the first WAIT_TX cycle, which must not be an exit cycle.
                if (!tx_start && !tx_busy) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_q       <= 8'h00;
            addr_q      <= 8'h00;
            tx_start    <= 1'b0;
            tx_code     <= 8'h00;
            tx_value    <= 8'h00;
            timeout_cnt <= 32'd0;
        end else begin
            if (req_load) begin
                cmd_q  <= req_cmd;
                addr_q <= req_addr;
            end
            if (rsp_load) begin
                tx_code  <= rsp_code;
                tx_value <= rsp_value;
            end
            tx_start <= start_tx;
            if (state == ST_ISSUE) begin
                timeout_cnt <= 32'd0;
            end else if (state == ST_WAIT_SENSOR) begin
                timeout_cnt <= timeout_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            slot_active  <= 1'b0;
            slot_hum     <= 1'b0;
            slot_addr    <= 8'h00;
            period_cnt   <= 32'd0;
            tick_pending <= 1'b0;
        end else if (slot_load) begin
            slot_active  <= 1'b1;
            slot_hum     <= (cmd_q == CMD_CONT_HUM_ON);
            slot_addr    <= addr_q;
            period_cnt   <= 32'd0;
            tick_pending <= 1'b0;
        end else if (slot_clear) begin
            slot_active  <= 1'b0;
            period_cnt   <= 32'd0;
            tick_pending <= 1'b0;
        end else if (slot_active) begin
            if (tick_take) begin
                tick_pending <= 1'b0;
            end
            // A tick stays latched until IDLE consumes it.
            if (period_cnt == PERIOD_LAST) begin
                period_cnt   <= 32'd0;
                tick_pending <= 1'b1;
            end else begin
                period_cnt <= period_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_sensor_request_dispatcher.sv
// Directed bench for sensor_request_dispatcher with short timeout and period settings.
module tb_sensor_request_dispatcher;

    localparam int N = 32;

    logic            clock = 1'b0;
    logic            reset;
    logic            rx_valid;
    logic [7:0]      rx_command, rx_address;
    logic [N-1:0]    sensor_start, sensor_done, sensor_error;
    logic [16*N-1:0] sensor_data;
    logic            tx_start, tx_busy, busy;
    logic [7:0]      tx_code, tx_value;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int start_cnt  = 0;
    int tx_cnt     = 0;

    sensor_request_dispatcher #(
        .NUM_SENSORS    (N),
        .TIMEOUT_CYCLES (100),
        .PERIOD_CYCLES  (1000)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_command   (rx_command),
        .rx_address   (rx_address),
        .sensor_start (sensor_start),
        .sensor_done  (sensor_done),
        .sensor_error (sensor_error),
        .sensor_data  (sensor_data),
        .tx_start     (tx_start),
        .tx_code      (tx_code),
        .tx_value     (tx_value),
        .tx_busy      (tx_busy),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (|sensor_start) start_cnt <= start_cnt + 1;
        if (tx_start) tx_cnt <= tx_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] c, input logic [7:0] a);
        rx_command = c;
        rx_address = a;
        rx_valid   = 1'b1;
        tick();
        rx_valid   = 1'b0;
    endtask

    // n = ticks taken until the pulse is visible, -1 if it never came.
    task automatic wait_for(input bit want_tx, input int max_ticks, output int n);
        n = 0;
        while (((want_tx ? tx_start : |sensor_start) !== 1'b1) && n < max_ticks) begin
            tick();
            n++;
        end
        if ((want_tx ? tx_start : |sensor_start) !== 1'b1) n = -1;
    endtask

    task automatic respond(input int ch, input bit done, input bit err);
        tick();
        sensor_done[ch]  = done;
        sensor_error[ch] = err;
        tick();
        sensor_done  = '0;
        sensor_error = '0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 300) begin
            tick();
            n++;
        end
        check("return_to_idle", busy, 1'b0);
    endtask

    initial begin
        int n, sc, tc, c1, c2, c3;
        reset        = 1'b1;
        rx_valid     = 1'b0;
        rx_command   = 8'h00;
        rx_address   = 8'h00;
        sensor_done  = '0;
        sensor_error = '0;
        tx_busy      = 1'b0;
        for (int i = 0; i < N; i++) sensor_data[16*i +: 16] = 16'hA5C3;
        sensor_data[16*5 +: 16] = 16'h3719;
        sensor_data[16*7 +: 16] = 16'h5A21;
        sensor_data[16*4 +: 16] = 16'h2211;
        sensor_data[16*2 +: 16] = 16'h4433;
        sensor_data[16*1 +: 16] = 16'h6655;
        repeat (3) tick();
        reset = 1'b0;
        check("reset_busy", busy, 1'b0);
        check("reset_tx_start", tx_start, 1'b0);
        check("reset_sensor_start", sensor_start, '0);
        check("reset_tx_code", tx_code, 8'h00);
        check("reset_tx_value", tx_value, 8'h00);

        // Invalid address: response three cycles after rx_valid, no channel started
        sc = start_cnt;
        send_rx(8'h01, 8'h40);
        wait_for(1'b1, 20, n);
        check("bad_addr_latency", n, 2);
        check("bad_addr_code", tx_code, 8'hEF);
        check("bad_addr_value", tx_value, 8'h40);
        check("bad_addr_no_start", start_cnt, sc);
        wait_idle();

        // Address is checked before command
        send_rx(8'h09, 8'h40);
        wait_for(1'b1, 20, n);
        check("addr_before_cmd_code", tx_code, 8'hEF);
        wait_idle();
        send_rx(8'h09, 8'h01);
        wait_for(1'b1, 20, n);
        check("bad_cmd_code", tx_code, 8'hCF);
        check("bad_cmd_value", tx_value, 8'h09);
        wait_idle();

        // Temperature read on channel 5
        send_rx(8'h01, 8'h05);
        wait_for(1'b0, 20, n);
        check("temp_start_latency", n, 1);
        check("temp_start_onehot", sensor_start, 32'h0000_0020);
        respond(5, 1'b1, 1'b0);
        check("start_single_cycle", sensor_start, '0);
        wait_for(1'b1, 20, n);
        check("temp_code", tx_code, 8'h09);
        check("temp_value", tx_value, 8'h19);
        wait_idle();

        // Humidity on channel 7; done on channel 6 must be ignored
        send_rx(8'h02, 8'h07);
        wait_for(1'b0, 20, n);
        respond(6, 1'b1, 1'b0);
        check("ignore_other_channel", busy, 1'b1);
        check("ignore_other_no_tx", tx_start, 1'b0);
        respond(7, 1'b1, 1'b0);
        wait_for(1'b1, 20, n);
        check("hum_code", tx_code, 8'h08);
        check("hum_value", tx_value, 8'h5A);
        wait_idle();

        // Timeout on silent channel 3
        send_rx(8'h02, 8'h03);
        wait_for(1'b1, 200, n);
        check("timeout_latency", n, 103);
        check("timeout_code", tx_code, 8'h2F);
        check("timeout_value", tx_value, 8'h03);
        wait_idle();

        // Error wins over simultaneous done
        send_rx(8'h01, 8'h03);
        wait_for(1'b0, 20, n);
        respond(3, 1'b1, 1'b1);
        wait_for(1'b1, 20, n);
        check("err_code", tx_code, 8'h1F);
        check("err_value", tx_value, 8'h03);
        wait_idle();

        // Three requests while busy: only the first is buffered
        sc = start_cnt;
        tc = tx_cnt;
        send_rx(8'h01, 8'h04);
        wait_for(1'b0, 20, n);
        send_rx(8'h02, 8'h04);
        send_rx(8'h00, 8'h01);
        send_rx(8'h01, 8'h02);
        respond(4, 1'b1, 1'b0);
        wait_for(1'b1, 20, n);
        check("queue_first_code", tx_code, 8'h09);
        check("queue_first_value", tx_value, 8'h11);
        wait_for(1'b0, 20, n);
        check("queue_second_start", sensor_start, 32'h0000_0010);
        respond(4, 1'b1, 1'b0);
        wait_for(1'b1, 20, n);
        check("queue_second_code", tx_code, 8'h08);
        check("queue_second_value", tx_value, 8'h22);
        wait_idle();
        repeat (30) tick();
        check("queue_tx_count", tx_cnt - tc, 2);
        check("queue_start_count", start_cnt - sc, 2);
        check("tx_code_held", tx_code, 8'h08);

        // tx_busy holds the response back
        tx_busy = 1'b1;
        send_rx(8'h00, 8'h02);
        wait_for(1'b0, 20, n);
        respond(2, 1'b1, 1'b0);
        tc = tx_cnt;
        repeat (50) tick();
        check("busy_holds_tx", tx_cnt, tc);
        tx_busy = 1'b0;
        wait_for(1'b1, 5, n);
        check("busy_release_latency", n, 1);
        check("status_code", tx_code, 8'h07);
        check("status_value", tx_value, 8'h00);
        tx_busy = 1'b1;
        repeat (5) tick();
        check("wait_tx_holds", busy, 1'b1);
        tx_busy = 1'b0;
        tick();
        check("wait_tx_exit", busy, 1'b0);

        // Continuous temperature on channel 2
        send_rx(8'h03, 8'h02);
        wait_for(1'b0, 20, n);
        check("cont_start_latency", n, 1);
        check("cont_start_onehot", sensor_start, 32'h0000_0004);
        respond(2, 1'b1, 1'b0);
        wait_for(1'b1, 20, n);
        check("cont_code", tx_code, 8'h09);
        check("cont_value", tx_value, 8'h33);
        wait_idle();
        wait_for(1'b0, 1100, n);
        c1 = cyc;
        check("cont_tick_start", sensor_start, 32'h0000_0004);
        respond(2, 1'b1, 1'b0);
        wait_for(1'b1, 20, n);
        check("cont_tick_code", tx_code, 8'h09);
        wait_idle();
        wait_for(1'b0, 1100, n);
        c2 = cyc;
        check("cont_period", c2 - c1, 1000);
        respond(2, 1'b1, 1'b0);
        wait_for(1'b1, 20, n);
        wait_idle();
        wait_for(1'b0, 1100, n);
        c3 = cyc;
        check("cont_period_again", c3 - c2, 1000);
        respond(2, 1'b1, 1'b0);
        wait_for(1'b1, 20, n);
        wait_idle();

        // Continuous temperature off
        send_rx(8'h05, 8'h00);
        wait_for(1'b1, 20, n);
        check("cont_off_latency", n, 2);
        check("cont_off_code", tx_code, 8'h0A);
        check("cont_off_value", tx_value, 8'h00);
        wait_idle();
        sc = start_cnt;
        repeat (2100) tick();
        check("cont_off_no_starts", start_cnt, sc);

        // Reset mid-WAIT_SENSOR with a continuous slot loaded
        send_rx(8'h04, 8'h01);
        wait_for(1'b0, 20, n);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset_busy", busy, 1'b0);
        check("midreset_tx_code", tx_code, 8'h00);
        check("midreset_tx_value", tx_value, 8'h00);
        check("midreset_tx_start", tx_start, 1'b0);
        sc = start_cnt;
        tc = tx_cnt;
        repeat (1200) tick();
        check("midreset_no_starts", start_cnt, sc);
        check("midreset_no_tx", tx_cnt, tc);
        send_rx(8'h02, 8'h01);
        wait_for(1'b0, 20, n);
        check("post_reset_latency", n, 1);
        check("post_reset_onehot", sensor_start, 32'h0000_0002);
        respond(1, 1'b1, 1'b0);
        wait_for(1'b1, 20, n);
        check("post_reset_code", tx_code, 8'h08);
        check("post_reset_value", tx_value, 8'h66);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
